// File: rtl/trap_controller_pkg.sv
// Shared types and constants for the trap controller: XLEN, FSM states,
// RISC-V machine-mode exception/interrupt codes and an mcause builder.
`timescale 1ns/1ps
package trap_controller_pkg;

   localparam int XLEN           = 32;
   localparam int MCAUSE_INT_BIT = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      REDIR = 2'd2,
      RET   = 2'd3
   } trap_state_t;

   typedef logic [30:0] exc_code_t;

   localparam exc_code_t EXC_FETCH_MIS = 31'd0;
   localparam exc_code_t EXC_ILLEGAL   = 31'd2;
   localparam exc_code_t EXC_BREAK     = 31'd3;
   localparam exc_code_t EXC_LOAD_MIS  = 31'd4;
   localparam exc_code_t EXC_STORE_MIS = 31'd6;
   localparam exc_code_t EXC_ECALL_M   = 31'd11;
   localparam exc_code_t IRQ_M_TIMER   = 31'd7;
   localparam exc_code_t IRQ_M_EXT     = 31'd11;

   function automatic logic [31:0] mk_cause(input logic is_irq, input exc_code_t code);
      logic [31:0] v;
      v                 = {1'b0, code};
      v[MCAUSE_INT_BIT] = is_irq;
      return v;
   endfunction

endpackage

// File: rtl/trap_controller_irq_sync.sv
// irq_sync: N-stage flip-flop synchroniser for one asynchronous level input.
// Depths below 2 are clamped to 2.
`timescale 1ns/1ps
module irq_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   localparam int N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] r_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[N-2:0], d_i};
      end
   end

   assign q_o = r_sync[N-1];

endmodule

// File: rtl/trap_controller.sv
// trap_controller: prioritises exceptions/interrupts, issues the CSR trap
// request and redirects fetch; also sequences MRET. Option: TRAP_VECTORED_EN.
`timescale 1ns/1ps
module trap_controller
   import trap_controller_pkg::*;
#(
   parameter int IRQ_SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_i,
   input  logic            instrValid_i,
   input  logic            excIllegal_i,
   input  logic            excEcall_i,
   input  logic            excEbreak_i,
   input  logic            excFetchMis_i,
   input  logic            excLoadMis_i,
   input  logic            excStoreMis_i,
   input  logic [XLEN-1:0] badAddr_i,
   input  logic [31:0]     instr_i,
   input  logic            mret_i,
   input  logic            irqExt_i,
   input  logic            irqTimer_i,
   input  logic            mieGlobal_i,
   input  logic [XLEN-1:0] mtvec_i,
   input  logic [XLEN-1:0] mepc_i,
   output logic            excRequest_o,
   output logic [31:0]     excCause_o,
   output logic [31:0]     trapInfo_o,
   output logic [XLEN-1:0] excPc_o,
   output logic            stall_o,
   output logic            flush_o,
   output logic            pcRedirect_o,
   output logic [XLEN-1:0] pcTarget_o
);

   trap_state_t     r_state;
   trap_state_t     w_state_next;
   logic [31:0]     r_cause;
   logic [31:0]     r_info;
   logic [XLEN-1:0] r_epc;

   logic            w_irq_ext_sync;
   logic            w_irq_timer_sync;
   logic            w_trap;
   logic            w_is_irq;
   logic [31:0]     w_cause;
   logic [31:0]     w_info;
   logic [XLEN-1:0] w_base;
   logic [XLEN-1:0] w_trap_target;
   logic            w_stall;
   logic            w_flush;
   logic            w_req;
   logic            w_redir;
   logic [XLEN-1:0] w_target;
   logic            w_unused;

   irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_ext (
      .clk (clk),
      .rst (rst),
      .d_i (irqExt_i),
      .q_o (w_irq_ext_sync)
   );

   irq_sync #(.STAGES(IRQ_SYNC_STAGES)) u_sync_timer (
      .clk (clk),
      .rst (rst),
      .d_i (irqTimer_i),
      .q_o (w_irq_timer_sync)
   );

   // Fixed priority: synchronous exceptions first, then external, then timer.
   always_comb begin
      w_trap   = 1'b0;
      w_is_irq = 1'b0;
      w_cause  = '0;
      w_info   = '0;
      if (instrValid_i) begin
         w_trap = 1'b1;
         if (excFetchMis_i) begin
            w_cause = mk_cause(1'b0, EXC_FETCH_MIS);
            w_info  = 32'(badAddr_i);
         end else if (excIllegal_i) begin
            w_cause = mk_cause(1'b0, EXC_ILLEGAL);
            w_info  = instr_i;
         end else if (excEbreak_i) begin
            w_cause = mk_cause(1'b0, EXC_BREAK);
            w_info  = 32'(pc_i);
         end else if (excLoadMis_i) begin
            w_cause = mk_cause(1'b0, EXC_LOAD_MIS);
            w_info  = 32'(badAddr_i);
         end else if (excStoreMis_i) begin
            w_cause = mk_cause(1'b0, EXC_STORE_MIS);
            w_info  = 32'(badAddr_i);
         end else if (excEcall_i) begin
            w_cause = mk_cause(1'b0, EXC_ECALL_M);
         end else if (w_irq_ext_sync && mieGlobal_i) begin
            w_cause  = mk_cause(1'b1, IRQ_M_EXT);
            w_is_irq = 1'b1;
         end else if (w_irq_timer_sync && mieGlobal_i) begin
            w_cause  = mk_cause(1'b1, IRQ_M_TIMER);
            w_is_irq = 1'b1;
         end else begin
            w_trap = 1'b0;
         end
      end
   end

   assign w_base = {mtvec_i[XLEN-1:2], 2'b00};

`ifdef TRAP_VECTORED_EN
   logic r_is_irq;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_is_irq <= 1'b0;
      end else if (r_state == IDLE && w_trap) begin
         r_is_irq <= w_is_irq;
      end
   end

   assign w_trap_target = r_is_irq ? (w_base + {r_cause[XLEN-3:0], 2'b00}) : w_base;
   assign w_unused      = &{1'b0, mtvec_i[1:0], mepc_i[1:0]};
`else
   assign w_trap_target = w_base;
   assign w_unused      = &{1'b0, mtvec_i[1:0], mepc_i[1:0], w_is_irq};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
         r_cause <= '0;
         r_info  <= '0;
         r_epc   <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == IDLE && w_trap) begin
            r_cause <= w_cause;
            r_info  <= w_info;
            r_epc   <= pc_i;
         end
      end
   end

   // Detect-cycle stall is combinational, so gate it while reset is held.
   always_comb begin
      w_state_next = r_state;
      w_stall      = 1'b0;
      w_flush      = 1'b0;
      w_req        = 1'b0;
      w_redir      = 1'b0;
      w_target     = '0;
      case (r_state)
         IDLE: begin
            if (w_trap) begin
               w_state_next = REQ;
               w_stall      = rst;
            end else if (mret_i) begin
               w_state_next = RET;
            end
         end
         REQ: begin
            w_req        = 1'b1;
            w_stall      = 1'b1;
            w_flush      = 1'b1;
            w_state_next = REDIR;
         end
         REDIR: begin
            w_redir      = 1'b1;
            w_target     = w_trap_target;
            w_state_next = IDLE;
         end
         RET: begin
            w_redir      = 1'b1;
            w_flush      = 1'b1;
            w_target     = {mepc_i[XLEN-1:2], 2'b00};
            w_state_next = IDLE;
         end
         default: w_state_next = IDLE;
      endcase
   end

   assign excRequest_o = w_req;
   assign excCause_o   = r_cause;
   assign trapInfo_o   = r_info;
   assign excPc_o      = r_epc;
   assign stall_o      = w_stall;
   assign flush_o      = w_flush;
   assign pcRedirect_o = w_redir;
   assign pcTarget_o   = w_target;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: table of single-trap vectors plus
// hand-written interrupt, reset-during-request and back-to-back sequences.
`timescale 1ns/1ps
module tb_trap_controller;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i, badAddr_i, instr_i, mtvec_i, mepc_i;
   logic        instrValid_i, excIllegal_i, excEcall_i, excEbreak_i;
   logic        excFetchMis_i, excLoadMis_i, excStoreMis_i;
   logic        mret_i, irqExt_i, irqTimer_i, mieGlobal_i;
   logic        excRequest_o, stall_o, flush_o, pcRedirect_o;
   logic [31:0] excCause_o, trapInfo_o, excPc_o, pcTarget_o;

   int n_checks = 0;
   int n_fail   = 0;

   trap_controller #(.IRQ_SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst           (rst),
      .pc_i          (pc_i),
      .instrValid_i  (instrValid_i),
      .excIllegal_i  (excIllegal_i),
      .excEcall_i    (excEcall_i),
      .excEbreak_i   (excEbreak_i),
      .excFetchMis_i (excFetchMis_i),
      .excLoadMis_i  (excLoadMis_i),
      .excStoreMis_i (excStoreMis_i),
      .badAddr_i     (badAddr_i),
      .instr_i       (instr_i),
      .mret_i        (mret_i),
      .irqExt_i      (irqExt_i),
      .irqTimer_i    (irqTimer_i),
      .mieGlobal_i   (mieGlobal_i),
      .mtvec_i       (mtvec_i),
      .mepc_i        (mepc_i),
      .excRequest_o  (excRequest_o),
      .excCause_o    (excCause_o),
      .trapInfo_o    (trapInfo_o),
      .excPc_o       (excPc_o),
      .stall_o       (stall_o),
      .flush_o       (flush_o),
      .pcRedirect_o  (pcRedirect_o),
      .pcTarget_o    (pcTarget_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef TRAP_VECTORED_EN
   localparam logic [31:0] EXT_TARGET   = 32'h0000_042C;
   localparam logic [31:0] TIMER_TARGET = 32'h0000_041C;
`else
   localparam logic [31:0] EXT_TARGET   = 32'h0000_0400;
   localparam logic [31:0] TIMER_TARGET = 32'h0000_0400;
`endif

   // kind: 0 = trap, 1 = mret, 2 = nothing taken
   typedef struct {
      string       name;
      logic        valid;
      logic [5:0]  exc;   // {fetchMis, illegal, ebreak, loadMis, storeMis, ecall}
      logic        mret;
      logic [31:0] pc, bad, instr, mtvec, mepc;
      int          kind;
      logic [31:0] cause, info, target;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string nm, input logic v, input logic [5:0] e, input logic m,
                          input logic [31:0] pc, input logic [31:0] bad, input logic [31:0] ins,
                          input logic [31:0] tv, input logic [31:0] ep, input int k,
                          input logic [31:0] c, input logic [31:0] inf, input logic [31:0] tgt);
      vec_t r;
      r.name = nm; r.valid = v; r.exc = e; r.mret = m; r.pc = pc; r.bad = bad;
      r.instr = ins; r.mtvec = tv; r.mepc = ep; r.kind = k;
      r.cause = c; r.info = inf; r.target = tgt;
      vecs.push_back(r);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_flags();
      instrValid_i  = 1'b0;
      excIllegal_i  = 1'b0; excEcall_i   = 1'b0; excEbreak_i   = 1'b0;
      excFetchMis_i = 1'b0; excLoadMis_i = 1'b0; excStoreMis_i = 1'b0;
      mret_i        = 1'b0;
   endtask

   task automatic run_vec(input vec_t r);
      pc_i = r.pc; badAddr_i = r.bad; instr_i = r.instr; mtvec_i = r.mtvec; mepc_i = r.mepc;
      instrValid_i = r.valid;
      {excFetchMis_i, excIllegal_i, excEbreak_i, excLoadMis_i, excStoreMis_i, excEcall_i} = r.exc;
      mret_i = r.mret;
      #1;
      chk({r.name, " detect stall"}, 32'(stall_o), (r.kind == 0) ? 32'd1 : 32'd0);
      step();
      chk({r.name, " request"}, 32'(excRequest_o), (r.kind == 0) ? 32'd1 : 32'd0);
      if (r.kind == 0) begin
         chk({r.name, " cause"}, excCause_o, r.cause);
         chk({r.name, " info"}, trapInfo_o, r.info);
         chk({r.name, " epc"}, excPc_o, r.pc);
         chk({r.name, " req flush"}, 32'(flush_o), 32'd1);
      end else if (r.kind == 1) begin
         chk({r.name, " ret redirect"}, 32'(pcRedirect_o), 32'd1);
         chk({r.name, " ret target"}, pcTarget_o, r.target);
         chk({r.name, " ret flush"}, 32'(flush_o), 32'd1);
      end else begin
         chk({r.name, " no redirect"}, 32'(pcRedirect_o), 32'd0);
      end
      clear_flags();
      if (r.kind == 0) begin
         step();
         chk({r.name, " redirect"}, 32'(pcRedirect_o), 32'd1);
         chk({r.name, " target"}, pcTarget_o, r.target);
         chk({r.name, " redir stall"}, 32'(stall_o), 32'd0);
      end
      step();
      chk({r.name, " idle"}, 32'({excRequest_o, pcRedirect_o}), 32'd0);
      $display("vector %s done", r.name);
   endtask

   initial begin
      int n;
      int reqs;
      rst = 1'b0;
      clear_flags();
      irqExt_i = 1'b0; irqTimer_i = 1'b0; mieGlobal_i = 1'b0;
      pc_i = '0; badAddr_i = '0; instr_i = '0; mtvec_i = 32'h200; mepc_i = '0;

      add_vec("illegal",        1, 6'b010000, 0, 32'h100, 32'h0,    32'hFFFF_FFFF, 32'h200, 32'h0,   0, 32'd2,  32'hFFFF_FFFF, 32'h200);
      add_vec("loadmis+ecall",  1, 6'b000101, 0, 32'h104, 32'h1003, 32'h0,         32'h200, 32'h0,   0, 32'd4,  32'h1003,      32'h200);
      add_vec("fetchmis+ill",   1, 6'b110000, 0, 32'h108, 32'h2002, 32'h1234,      32'h200, 32'h0,   0, 32'd0,  32'h2002,      32'h200);
      add_vec("ebreak",         1, 6'b001000, 0, 32'h10C, 32'h0,    32'h0,         32'h200, 32'h0,   0, 32'd3,  32'h10C,       32'h200);
      add_vec("storemis+ecall", 1, 6'b000011, 0, 32'h110, 32'h55,   32'h0,         32'h200, 32'h0,   0, 32'd6,  32'h55,        32'h200);
      add_vec("ecall",          1, 6'b000001, 0, 32'h114, 32'h77,   32'h0,         32'h200, 32'h0,   0, 32'd11, 32'h0,         32'h200);
      add_vec("mret",           1, 6'b000000, 1, 32'h118, 32'h0,    32'h0,         32'h200, 32'h3C4, 1, 32'd0,  32'h0,         32'h3C4);
      add_vec("mret+ecall",     1, 6'b000001, 1, 32'h11C, 32'h0,    32'h0,         32'h200, 32'h3C4, 0, 32'd11, 32'h0,         32'h200);
      add_vec("invalid ill",    0, 6'b010000, 0, 32'h120, 32'h0,    32'h0,         32'h200, 32'h0,   2, 32'd0,  32'h0,         32'h0);
      add_vec("mtvec mask",     1, 6'b010000, 0, 32'h124, 32'h0,    32'hABCD,      32'h203, 32'h0,   0, 32'd2,  32'hABCD,      32'h200);
      add_vec("mepc mask",      0, 6'b000000, 1, 32'h128, 32'h0,    32'h0,         32'h200, 32'h3C7, 1, 32'd0,  32'h0,         32'h3C4);

      // Reset state, with an exception flag held to show the stall is gated.
      #12;
      instrValid_i = 1'b1; excIllegal_i = 1'b1;
      #1;
      chk("reset stall", 32'(stall_o), 32'd0);
      chk("reset outputs", 32'({excRequest_o, flush_o, pcRedirect_o}), 32'd0);
      chk("reset cause", excCause_o, 32'd0);
      chk("reset target", pcTarget_o, 32'd0);
      clear_flags();
      @(negedge clk);
      rst = 1'b1;
      step();

      foreach (vecs[i]) run_vec(vecs[i]);

      // External interrupt: two sync stages plus the detect cycle.
      mtvec_i = 32'h400; pc_i = 32'h180;
      mieGlobal_i = 1'b1; instrValid_i = 1'b1; irqExt_i = 1'b1;
      n = 0;
      while (n < 8) begin
         step();
         n++;
         if (excRequest_o) break;
      end
      chk("irq ext latency", 32'(n), 32'd3);
      chk("irq ext cause", excCause_o, 32'h8000_000B);
      chk("irq ext info", trapInfo_o, 32'h0);
      chk("irq ext epc", excPc_o, 32'h180);
      mieGlobal_i = 1'b0; irqExt_i = 1'b0;
      step();
      chk("irq ext target", pcTarget_o, EXT_TARGET);
      reqs = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         if (excRequest_o) reqs++;
      end
      chk("irq ext drained", 32'(reqs), 32'd0);
      $display("sequence irq ext done");

      // Timer interrupt masked by MIE, then by instrValid, then taken.
      irqTimer_i = 1'b1; pc_i = 32'h184;
      reqs = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (excRequest_o) reqs++;
      end
      chk("irq timer masked", 32'(reqs), 32'd0);
      instrValid_i = 1'b0; mieGlobal_i = 1'b1;
      #1;
      chk("irq invalid stall", 32'(stall_o), 32'd0);
      step();
      chk("irq invalid req", 32'(excRequest_o), 32'd0);
      instrValid_i = 1'b1;
      #1;
      chk("irq timer stall", 32'(stall_o), 32'd1);
      step();
      chk("irq timer req", 32'(excRequest_o), 32'd1);
      chk("irq timer cause", excCause_o, 32'h8000_0007);
      mieGlobal_i = 1'b0; irqTimer_i = 1'b0;
      step();
      chk("irq timer target", pcTarget_o, TIMER_TARGET);
      step(); step(); step();
      clear_flags();
      $display("sequence irq timer done");

      // Reset during REQ, then the held flag re-traps, then back-to-back.
      mtvec_i = 32'h200; pc_i = 32'h140; instr_i = 32'h1234_5678;
      instrValid_i = 1'b1; excIllegal_i = 1'b1;
      step();
      chk("pre-reset req", 32'(excRequest_o), 32'd1);
      rst = 1'b0;
      #1;
      chk("async reset req", 32'(excRequest_o), 32'd0);
      chk("async reset stall/flush", 32'({stall_o, flush_o}), 32'd0);
      chk("async reset cause", excCause_o, 32'd0);
      chk("async reset epc", excPc_o, 32'd0);
      step();
      chk("held reset", 32'({excRequest_o, stall_o, pcRedirect_o}), 32'd0);
      rst = 1'b1;
      #1;
      chk("post-reset stall", 32'(stall_o), 32'd1);
      step();
      chk("post-reset req", 32'(excRequest_o), 32'd1);
      chk("post-reset info", trapInfo_o, 32'h1234_5678);
      step();
      chk("b2b redirect", 32'(pcRedirect_o), 32'd1);
      step();
      chk("b2b detect", 32'({excRequest_o, stall_o}), 32'd1);
      step();
      chk("b2b req", 32'(excRequest_o), 32'd1);
      clear_flags();
      step(); step();
      chk("final idle", 32'({excRequest_o, pcRedirect_o, stall_o}), 32'd0);
      $display("sequence reset/back-to-back done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
